// File: rtl/mem_loader_pkg.sv
// Shared definitions for the byte-stream RAM loader: FSM encoding, bus release value, helpers.
// No logic of its own; imported by the loader datapath.
// Backpressure behaviour is defined by the users of these types.
package mem_loader_pkg;

  // Loader FSM states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Value placed on the shared system bus whenever the loader is not writing.
  localparam logic [7:0] BUS_Z = 8'bzzzzzzzz;

  // A length field of zero stands for a full 256-byte page.
  function automatic logic [8:0] len_to_count(input logic [7:0] len_field);
    if (len_field == 8'd0) begin
      return 9'd256;
    end
    return {1'b0, len_field};
  endfunction

endpackage

// File: rtl/mem_loader.sv
// Streams len bytes from a valid/ready source into RAM starting at base, then checks a trailing checksum.
// Two cycles per byte (RECV accept, WRITE commit); done pulses one cycle after the last byte or checksum.
// Holds in_ready high in RECV/CHECK only; any upstream stall parks the FSM with no side effects.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int CHECKSUM_EN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] base,
  input  logic [7:0] len,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic [7:0] addr,
  output logic       ie,
  inout  wire  [7:0] bus,
  output logic       busy,
  output logic       done,
  output logic       err
);

  state_t     state;
  state_t     state_n;
  logic [7:0] ptr;
  logic [8:0] remaining;
  logic [7:0] sum;
  logic [7:0] data_q;
  logic       err_q;
  logic       accept;
  logic [7:0] check_total;

  // A byte is taken whenever the source offers one while we are listening.
  assign accept      = in_valid && in_ready;
  // Running sum including the incoming byte; zero means the checksum matches.
  assign check_total = sum + in_data;

  // The bus is only ours during the single WRITE cycle; otherwise it is released.
  assign bus = ie ? data_q : BUS_Z;

  assign err = err_q;

  // State register; reset wins over everything else in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state selection and per-state output decode.
  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    ie       = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    addr     = ptr;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        addr = 8'd0;
        if (start) begin
          state_n = ST_RECV;
        end
      end
      ST_RECV: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_n = ST_WRITE;
        end
      end
      ST_WRITE: begin
        ie = 1'b1;
        if (remaining > 9'd1) begin
          state_n = ST_RECV;
        end else if (CHECKSUM_EN != 0) begin
          state_n = ST_CHECK;
        end else begin
          state_n = ST_DONE;
        end
      end
      ST_CHECK: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_n = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
        busy    = 1'b0;
        addr    = 8'd0;
      end
    endcase
  end

  // Datapath: load parameters on start, latch and sum bytes, advance the pointer after each write.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= 8'd0;
      remaining <= 9'd0;
      sum       <= 8'd0;
      data_q    <= 8'd0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            ptr       <= base;
            remaining <= len_to_count(len);
            sum       <= 8'd0;
            err_q     <= 1'b0;
          end
        end
        ST_RECV: begin
          if (accept) begin
            data_q <= in_data;
            sum    <= check_total;
          end
        end
        ST_WRITE: begin
          // 8-bit pointer wraps naturally from 255 to 0.
          ptr       <= ptr + 8'd1;
          remaining <= remaining - 9'd1;
        end
        ST_CHECK: begin
          // Written bytes stay in RAM regardless; err only reports the mismatch.
          if (accept) begin
            err_q <= (check_total != 8'd0);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: random byte streams against a RAM image model.
// Expected RAM contents, write counts and checksum results are computed from the load parameters.
// Upstream valid is randomly withheld to exercise stalls.
module tb_mem_loader;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] base;
  logic [7:0] len;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] addr;
  logic       ie;
  wire  [7:0] bus;
  logic       busy;
  logic       done;
  logic       err;

  int total;
  int bad;

  // Environment RAM (written on falling edge) and expected image.
  logic [7:0] ram     [256];
  logic [7:0] exp_mem [256];
  logic       ram_clr;

  // Monitor state: free-running counters, only written by the monitor.
  int         wr_total;
  int         done_total;
  int         viol_total;
  logic       prev_acc;
  logic [7:0] prev_data;

  logic [7:0] tx_q[$];

  mem_loader #(.CHECKSUM_EN(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base     (base),
    .len      (len),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .addr     (addr),
    .ie       (ie),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM behaviour plus protocol watch: a write must follow an accepted byte, carry that byte,
  // and never coincide with in_ready.
  always @(negedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 256; i++) ram[i] = 8'hA5;
    end else if (ie) begin
      ram[addr] = bus;
    end
    if (ie) begin
      wr_total = wr_total + 1;
      if (prev_acc !== 1'b1) viol_total = viol_total + 1;
      if (in_ready !== 1'b0) viol_total = viol_total + 1;
      if (bus !== prev_data) viol_total = viol_total + 1;
    end
    if (done === 1'b1) done_total = done_total + 1;
    prev_acc = in_valid && in_ready;
    if (in_valid && in_ready) prev_data = in_data;
  end

  initial begin
    wr_total   = 0;
    done_total = 0;
    viol_total = 0;
    prev_acc   = 1'b0;
    prev_data  = 8'h00;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) exp_mem[i] = 8'hA5;
    ram_clr = 1'b1;
    @(posedge clk); #1;
    ram_clr = 1'b0;
  endtask

  // Offer tx_q bytes in order, withholding valid stall_pct percent of the time.
  task automatic drive_stream(input int stall_pct);
    int   idx;
    int   guard;
    logic go;
    logic acc;
    idx   = 0;
    guard = 0;
    while (idx < tx_q.size() && guard < 5000) begin
      go       = ($urandom_range(99) >= stall_pct);
      in_valid = go;
      in_data  = go ? tx_q[idx] : 8'($urandom);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      guard++;
    end
    in_valid = 1'b0;
    chk("stream_timeout", 32'(guard >= 5000), 32'd0);
  endtask

  task automatic do_load(input string tag, input logic [7:0] b, input logic [7:0] l,
                         input int stall_pct, input logic good, input logic poke);
    int         n;
    logic [7:0] s;
    logic [7:0] c;
    logic [7:0] v;
    int         wr0;
    int         dn0;
    int         vi0;
    int         w;
    n = (l == 8'd0) ? 256 : int'(l);
    s = 8'd0;
    tx_q.delete();
    clear_mem();
    for (int i = 0; i < n; i++) begin
      v = 8'($urandom);
      tx_q.push_back(v);
      exp_mem[8'(int'(b) + i)] = v;
      s = s + v;
    end
    c = good ? (8'd0 - s) : (8'd1 - s);
    tx_q.push_back(c);
    wr0 = wr_total;
    dn0 = done_total;
    vi0 = viol_total;

    start = 1'b1; base = b; len = l;
    @(posedge clk); #1;
    start = 1'b0; base = 8'h00; len = 8'h00;
    chk({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    chk({tag, "_err_cleared"}, 32'(err), 32'd0);
    chk({tag, "_addr_base"}, 32'(addr), 32'(b));
    chk({tag, "_ready_recv"}, 32'(in_ready), 32'd1);
    if (poke) begin
      start = 1'b1; base = 8'hC0; len = 8'd9;
      @(posedge clk); #1;
      start = 1'b0; base = 8'h00; len = 8'h00;
      chk({tag, "_addr_after_poke"}, 32'(addr), 32'(b));
    end

    drive_stream(stall_pct);
    w = 0;
    while (busy === 1'b1 && w < 8) begin
      @(posedge clk); #1;
      w++;
    end
    chk({tag, "_idle_timeout"}, 32'(busy), 32'd0);
    chk({tag, "_write_count"}, 32'(wr_total - wr0), 32'(n));
    chk({tag, "_done_pulses"}, 32'(done_total - dn0), 32'd1);
    chk({tag, "_protocol"}, 32'(viol_total - vi0), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'(!good));
    chk({tag, "_addr_idle"}, 32'(addr), 32'd0);
    for (int i = 0; i < 256; i++) begin
      chk($sformatf("%s_ram_%02h", tag, i), 32'(ram[i]), 32'(exp_mem[i]));
    end
  endtask

  initial begin
    int         wr0;
    logic [7:0] b1;
    logic [7:0] b2;
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    start    = 1'b0;
    base     = 8'h00;
    len      = 8'h00;
    in_valid = 1'b0;
    in_data  = 8'h00;
    ram_clr  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_ie", 32'(ie), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst     = 1'b0;
    ram_clr = 1'b0;
    @(posedge clk); #1;

    // Basic three-byte load with matching checksum.
    do_load("good3", 8'h10, 8'd3, 0, 1'b1, 1'b0);

    // Same shape, wrong checksum: bytes still land, err raised and held.
    do_load("bad3", 8'h10, 8'd3, 30, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("err_held", 32'(err), 32'd1);

    // Pointer wrap across the top of the address space.
    do_load("wrap4", 8'hFE, 8'd4, 25, 1'b1, 1'b0);

    // Full page with heavy random stalling.
    do_load("page256", 8'($urandom), 8'd0, 40, 1'b1, 1'b0);

    // Reset in the middle of the second byte's write cycle.
    clear_mem();
    b1 = 8'($urandom);
    b2 = 8'($urandom);
    start = 1'b1; base = 8'h40; len = 8'd4;
    @(posedge clk); #1;
    start = 1'b0;
    tx_q.delete();
    tx_q.push_back(b1);
    drive_stream(0);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = b2;
    @(posedge clk); #1;
    chk("rstw_in_write", 32'(ie), 32'd1);
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    chk("rstw_ie", 32'(ie), 32'd0);
    chk("rstw_busy", 32'(busy), 32'd0);
    chk("rstw_in_ready", 32'(in_ready), 32'd0);
    chk("rstw_addr", 32'(addr), 32'd0);
    chk("rstw_done", 32'(done), 32'd0);
    rst = 1'b0; start = 1'b0;
    wr0 = wr_total;
    repeat (6) @(posedge clk);
    #1;
    chk("rstw_no_writes", 32'(wr_total - wr0), 32'd0);
    chk("rstw_busy_later", 32'(busy), 32'd0);
    chk("rstw_first_byte", 32'(ram[8'h40]), 32'(b1));
    in_valid = 1'b0;

    // Start pulse while busy must not disturb the running load.
    do_load("poke", 8'h80, 8'd3, 20, 1'b1, 1'b1);

    // A few more random loads.
    for (int k = 0; k < 4; k++) begin
      do_load($sformatf("rand%0d", k), 8'($urandom), 8'($urandom_range(1, 20)),
              int'($urandom_range(0, 60)), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
